// File: rtl/frame_buffer_manager_if.sv
// frame_buffer_manager_if: event inputs and address/status outputs of the triple-buffer controller
interface frame_buffer_manager_if #(parameter int CNT_W = 16);
  logic             writer_done;
  logic             vsync_sync2;
  logic             clr_cnt;
  logic [31:0]      w_frame_base_addr;
  logic [31:0]      r_frame_base_addr;
  logic             buf_swap;
  logic [1:0]       wr_idx;
  logic [1:0]       rd_idx;
  logic             ready_valid;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] repeat_cnt;
  modport master (
    output writer_done, vsync_sync2, clr_cnt,
    input  w_frame_base_addr, r_frame_base_addr, buf_swap, wr_idx, rd_idx, ready_valid, drop_cnt, repeat_cnt
  );
  modport slave (
    input  writer_done, vsync_sync2, clr_cnt,
    output w_frame_base_addr, r_frame_base_addr, buf_swap, wr_idx, rd_idx, ready_valid, drop_cnt, repeat_cnt
  );
endinterface

// File: rtl/frame_buffer_manager.sv
// frame_buffer_manager: triple-buffer index rotation between DDR frame writer and display reader
module frame_buffer_manager #(
  parameter logic [31:0] BASE_ADDR  = 32'h0100_0000,
  parameter logic [31:0] BUF_STRIDE = 32'h0010_0000,
  parameter int          CNT_W      = 16
) (
  input  logic                   clk_100Mhz,
  input  logic                   rst,
  frame_buffer_manager_if.slave  bus
);
  logic             done_d_q, vs_d_q, done_e, vs_e, both_e;
  logic [1:0]       wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, sp_idx_q, sp_idx_d;
  logic             ready_valid_q, ready_valid_d, buf_swap_q, buf_swap_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d, repeat_cnt_q, repeat_cnt_d;
  logic [31:0]      w_addr_q, w_addr_d, r_addr_q, r_addr_d;
  always_comb begin
    done_e        = bus.writer_done & ~done_d_q;
    vs_e          = bus.vsync_sync2 & ~vs_d_q;
    both_e        = done_e & vs_e;
    // simultaneous done+vsync hands the fresh frame straight to the reader
    wr_idx_d      = both_e ? rd_idx_q : done_e ? sp_idx_q : wr_idx_q;
    rd_idx_d      = both_e ? wr_idx_q : (vs_e & ready_valid_q) ? sp_idx_q : rd_idx_q;
    sp_idx_d      = both_e ? sp_idx_q : done_e ? wr_idx_q : (vs_e & ready_valid_q) ? rd_idx_q : sp_idx_q;
    ready_valid_d = vs_e ? 1'b0 : done_e ? 1'b1 : ready_valid_q;
    buf_swap_d    = vs_e & (done_e | ready_valid_q);
    drop_cnt_d    = bus.clr_cnt ? '0 :
                    (done_e & ready_valid_q & ~&drop_cnt_q) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    repeat_cnt_d  = bus.clr_cnt ? '0 :
                    (vs_e & ~done_e & ~ready_valid_q & ~&repeat_cnt_q) ? repeat_cnt_q + 1'b1 : repeat_cnt_q;
    w_addr_d      = BASE_ADDR + 32'(wr_idx_d) * BUF_STRIDE;
    r_addr_d      = BASE_ADDR + 32'(rd_idx_d) * BUF_STRIDE;
  end
  always_ff @(posedge clk_100Mhz) begin
    if (rst) begin
      done_d_q      <= 1'b1;
      vs_d_q        <= 1'b1;
      wr_idx_q      <= 2'd0;
      rd_idx_q      <= 2'd1;
      sp_idx_q      <= 2'd2;
      ready_valid_q <= 1'b0;
      buf_swap_q    <= 1'b0;
      drop_cnt_q    <= '0;
      repeat_cnt_q  <= '0;
      w_addr_q      <= BASE_ADDR;
      r_addr_q      <= BASE_ADDR + BUF_STRIDE;
    end else begin
      done_d_q      <= bus.writer_done;
      vs_d_q        <= bus.vsync_sync2;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      sp_idx_q      <= sp_idx_d;
      ready_valid_q <= ready_valid_d;
      buf_swap_q    <= buf_swap_d;
      drop_cnt_q    <= drop_cnt_d;
      repeat_cnt_q  <= repeat_cnt_d;
      w_addr_q      <= w_addr_d;
      r_addr_q      <= r_addr_d;
    end
  end
  assign bus.w_frame_base_addr = w_addr_q;
  assign bus.r_frame_base_addr = r_addr_q;
  assign bus.buf_swap          = buf_swap_q;
  assign bus.wr_idx            = wr_idx_q;
  assign bus.rd_idx            = rd_idx_q;
  assign bus.ready_valid       = ready_valid_q;
  assign bus.drop_cnt          = drop_cnt_q;
  assign bus.repeat_cnt        = repeat_cnt_q;
endmodule

// File: doc/frame_buffer_manager.md
Name: frame_buffer_manager

Overview:
Triple-buffer controller between AXI4_writer (producer) and AXI4_reader (consumer) in the clk_100Mhz domain. Replaces the two-buffer ping-pong swap so the writer never stalls and the reader never shows a half-written frame. Consumes writer frame-complete events and display vsync events. Produces registered DDR base addresses for writer and reader, plus swap/drop/repeat status for ILA/VIO debug.

Parameters:
BASE_ADDR, 32'h0100_0000, DDR byte address of buffer 0.
BUF_STRIDE, 32'h0010_0000, byte distance between consecutive buffers (buffer n at BASE_ADDR + n*BUF_STRIDE).
CNT_W, 16, width of the drop and repeat counters.

Ports:
clk_100Mhz  in  1  AXI/system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
writer_done  in  1  writer finished last burst of a frame; level or pulse, rising edge used.
vsync_sync2  in  1  display frame start, already synchronised to clk_100Mhz; 1-4 cycles wide, rising edge used.
clr_cnt  in  1  synchronous clear of drop_cnt and repeat_cnt.
w_frame_base_addr  out  32  base address the writer uses for the frame in progress.
r_frame_base_addr  out  32  base address the reader uses for the frame being displayed.
buf_swap  out  1  one-cycle pulse when the reader buffer changes.
wr_idx  out  2  writer buffer index.
rd_idx  out  2  reader buffer index.
ready_valid  out  1  spare buffer holds a completed, not-yet-displayed frame.
drop_cnt  out  CNT_W  completed frames overwritten before display; saturating.
repeat_cnt  out  CNT_W  vsyncs with no new frame (previous frame reshown); saturating.

Behaviour:
- Edge detect: registers done_d and vs_d; done_e = writer_done & ~done_d, vs_e = vsync_sync2 & ~vs_d.
- done_d and vs_d reset to 1, so an input high at reset release produces no event.
- State: wr_idx, rd_idx, sp_idx, ready_valid.
- Invariant: {wr_idx, rd_idx, sp_idx} is always a permutation of {0,1,2}. Index 3 is never produced.
- Reset values: wr_idx=0, rd_idx=1, sp_idx=2, ready_valid=0, buf_swap=0, drop_cnt=0, repeat_cnt=0, w_frame_base_addr=BASE_ADDR, r_frame_base_addr=BASE_ADDR+BUF_STRIDE.
- Events are evaluated each cycle; all updates take effect on the next edge.
- done_e only:
  - sp_idx<=wr_idx, wr_idx<=sp_idx, ready_valid<=1.
  - If ready_valid was 1, drop_cnt++ (the older ready frame is discarded).
- vs_e only, ready_valid=1:
  - rd_idx<=sp_idx, sp_idx<=rd_idx, ready_valid<=0, buf_swap<=1.
- vs_e only, ready_valid=0:
  - Indices unchanged, buf_swap stays 0, repeat_cnt++.
- done_e and vs_e in the same cycle (the just-completed frame is shown at once):
  - rd_idx<=wr_idx, wr_idx<=rd_idx, sp_idx unchanged, ready_valid<=0, buf_swap<=1.
  - If ready_valid was 1, drop_cnt++.
- No event: state holds, buf_swap<=0.
- Addresses are registered: w_frame_base_addr = BASE_ADDR + wr_idx*BUF_STRIDE, r_frame_base_addr likewise from rd_idx.
  - They update in the same cycle the indices update, i.e. 1 cycle after the event edge.
  - Computed with a 32-bit multiply-by-constant or add, wrapping modulo 2^32.
- Counters:
  - Saturate at all-ones; no wrap.
  - clr_cnt has priority over an increment in the same cycle; counters read 0 the next cycle.
- Reset mid-operation returns all state to reset values on the next edge, regardless of pending events. No event is remembered across reset.
- The writer and reader never share a buffer index in any cycle (wr_idx != rd_idx always).
- No handshake back-pressure: events are never lost or queued; at most one done and one vsync processed per cycle.

Test Plan:
1. Reset, then idle 10 cycles -> wr_idx=0, rd_idx=1, w addr 0x0100_0000, r addr 0x0110_0000, all counters 0, buf_swap never high.
2. writer_done pulse, 20 cycles later a 4-cycle vsync_sync2 -> after done: wr_idx=2, ready_valid=1; after vsync: rd_idx=0, r addr 0x0100_0000, exactly one buf_swap pulse 1 cycle after the vsync rising edge.
3. Three writer_done pulses with no vsync -> drop_cnt=2, ready_valid=1, wr_idx!=rd_idx checked every cycle; next vsync selects the last completed buffer.
4. Five vsyncs with no writer_done -> repeat_cnt=5, rd_idx stays 1, no buf_swap; then clr_cnt asserted together with a vsync -> counters 0.
5. writer_done and vsync rising edges in the same cycle from reset -> rd_idx=0, wr_idx=1, ready_valid=0, drop_cnt=0, buf_swap pulses once.
6. Random done/vsync streams for 10k cycles plus rst mid-stream -> permutation invariant holds every cycle; counters match a reference model; rst restores exact reset values next cycle; CNT_W=4 run saturates drop_cnt at 15.
